// File: rtl/fft4_seq_ctrl.sv
// fft4_seq_ctrl: sequencer for the 4-point in-place FFT core.
// Loads 4 samples, runs two butterfly stages with in-place write-back, drains in bit-reversed order.
module fft4_seq_ctrl #(
   parameter int BFLY_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       ld_we,
   output logic [1:0] ld_addr,
   output logic [1:0] sel,
   output logic       wb_we,
   output logic [1:0] rd_addr,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       busy,
   output logic       done
);
   typedef enum logic [2:0] {IDLE, LOAD, S1_RUN, S1_WB, S2_RUN, S2_WB, DRAIN, DONE} state_t;
   localparam logic [3:0] WAIT_LAST = 4'(BFLY_LAT - 1);
   state_t     state_q;
   logic [1:0] cnt_q;
   logic [3:0] wait_q;
   // cnt_q serves as load count in LOAD and drain count in DRAIN; it wraps to 0 on leaving either
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wait_q  <= '0;
      end else begin
         case (state_q)
            IDLE:   if (start) state_q <= LOAD;
            LOAD:   if (in_valid) begin
                       cnt_q <= cnt_q + 2'd1;
                       if (cnt_q == 2'd3) state_q <= S1_RUN;
                    end
            S1_RUN, S2_RUN:
                    if (wait_q == WAIT_LAST) begin
                       wait_q  <= '0;
                       state_q <= (state_q == S1_RUN) ? S1_WB : S2_WB;
                    end else wait_q <= wait_q + 4'd1;
            S1_WB:  state_q <= S2_RUN;
            S2_WB:  state_q <= DRAIN;
            DRAIN:  if (out_ready) begin
                       cnt_q <= cnt_q + 2'd1;
                       if (cnt_q == 2'd3) state_q <= DONE;
                    end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign in_ready  = state_q == LOAD;
   assign ld_we     = in_valid & in_ready;
   assign ld_addr   = in_ready ? cnt_q : 2'd0;
   assign sel       = (state_q == S1_RUN || state_q == S1_WB) ? 2'd1 :
                      (state_q == S2_RUN || state_q == S2_WB) ? 2'd2 : 2'd0;
   assign wb_we     = state_q == S1_WB || state_q == S2_WB;
   assign out_valid = state_q == DRAIN;
   assign rd_addr   = out_valid ? {cnt_q[0], cnt_q[1]} : 2'd0;
   assign out_last  = out_valid && cnt_q == 2'd3;
   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE;
endmodule

// File: tb/tb_fft4_seq_ctrl.sv
// tb_fft4_seq_ctrl: drives two controllers (BFLY_LAT 1 and 4) in lockstep against a phase-count model.
module tb_fft4_seq_ctrl;
   logic clk = 1'b0;
   logic rst, start, in_valid, out_ready;
   logic [1:0] in_ready, ld_we, wb_we, out_valid, out_last, busy, done;
   logic [1:0][1:0] ld_addr, sel, rd_addr;
   int checks = 0, failures = 0;
   int lat[2] = '{1, 4};
   int br[4] = '{0, 2, 1, 3};
   bit act[2];
   int nld[2], ncy[2], nout[2];
   int t = 0, t_start = 0;
   int last_done[2];
   always #5 clk = ~clk;
   fft4_seq_ctrl #(.BFLY_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready[0]),
      .ld_we(ld_we[0]), .ld_addr(ld_addr[0]), .sel(sel[0]), .wb_we(wb_we[0]), .rd_addr(rd_addr[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready), .out_last(out_last[0]), .busy(busy[0]), .done(done[0]));
   fft4_seq_ctrl #(.BFLY_LAT(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready[1]),
      .ld_we(ld_we[1]), .ld_addr(ld_addr[1]), .sel(sel[1]), .wb_we(wb_we[1]), .rd_addr(rd_addr[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready), .out_last(out_last[1]), .busy(busy[1]), .done(done[1]));
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
      end
   endtask
   function automatic bit ph_ld(input int i);
      return act[i] && nld[i] < 4;
   endfunction
   function automatic bit ph_cp(input int i);
      return act[i] && nld[i] == 4 && ncy[i] < 2 * (lat[i] + 1);
   endfunction
   function automatic bit ph_dr(input int i);
      return act[i] && ncy[i] == 2 * (lat[i] + 1) && nout[i] < 4;
   endfunction
   // {busy,done,in_ready,ld_we,ld_addr,sel,wb_we,out_valid,out_last,rd_addr}
   function automatic logic [12:0] expv(input int i, input logic iv);
      logic ld, cp, dr;
      logic [1:0] s, ra, la;
      ld = ph_ld(i);
      cp = ph_cp(i);
      dr = ph_dr(i);
      s  = cp ? ((ncy[i] < lat[i] + 1) ? 2'd1 : 2'd2) : 2'd0;
      ra = dr ? 2'(br[nout[i]]) : 2'd0;
      la = ld ? 2'(nld[i]) : 2'd0;
      return {act[i], act[i] && nout[i] == 4, ld, ld & iv, la, s,
              cp && (ncy[i] % (lat[i] + 1)) == lat[i], dr, dr && nout[i] == 3, ra};
   endfunction
   function automatic logic [12:0] gotv(input int i);
      return {busy[i], done[i], in_ready[i], ld_we[i], ld_addr[i], sel[i], wb_we[i],
              out_valid[i], out_last[i], rd_addr[i]};
   endfunction
   task automatic step();
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            act[i] = 0; nld[i] = 0; ncy[i] = 0; nout[i] = 0;
         end else if (!act[i]) begin
            if (start) begin
               act[i] = 1; nld[i] = 0; ncy[i] = 0; nout[i] = 0;
            end
         end else if (ph_ld(i)) begin
            if (in_valid) nld[i]++;
         end else if (ph_cp(i)) ncy[i]++;
         else if (ph_dr(i)) begin
            if (out_ready) nout[i]++;
         end else act[i] = 0;
      end
   endtask
   task automatic tick(input bit r, input bit s, input bit iv, input bit ordy, input bit en);
      rst = r; start = s; in_valid = iv; out_ready = ordy;
      #1;
      if (en) begin
         chk("outs_L1", 16'(gotv(0)), 16'(expv(0, iv)));
         chk("outs_L4", 16'(gotv(1)), 16'(expv(1, iv)));
         for (int i = 0; i < 2; i++) if (done[i]) last_done[i] = t;
         if (s && !r && !busy[0]) t_start = t;
      end
      @(posedge clk);
      step();
      t++;
      @(negedge clk);
   endtask
   initial begin
      int sin, sout;
      @(negedge clk);
      tick(1, 0, 0, 0, 0);
      repeat (2) tick(1, 0, 0, 0, 1);
      repeat (10) tick(0, 0, 0, 0, 1);
      // nominal: ideal handshakes, measure start-to-done latency
      last_done = '{-1, -1};
      tick(0, 1, 1, 1, 1);
      repeat (25) tick(0, 0, 1, 1, 1);
      for (int i = 0; i < 2; i++)
         chk(i ? "lat_L4" : "lat_L1", 16'(last_done[i] - t_start), 16'(1 + 4 + 2 * (lat[i] + 1) + 4));
      // backpressure with start held high throughout
      sin = 0; sout = 0;
      for (int k = 0; k < 40; k++) begin
         bit iv, ordy;
         iv = !(nld[0] == 2 && sin < 3);
         ordy = !(ph_dr(0) && nout[0] == 1 && sout < 2);
         if (!iv) sin++;
         if (!ordy) sout++;
         tick(0, 1, iv, ordy, 1);
      end
      repeat (30) tick(0, 0, 1, 1, 1);
      // abort in stage 2 of the BFLY_LAT=1 controller
      tick(0, 1, 1, 1, 1);
      for (int k = 0; k < 20 && !(ph_cp(0) && ncy[0] == lat[0] + 1); k++) tick(0, 0, 1, 1, 1);
      tick(1, 0, 1, 1, 1);
      repeat (3) tick(0, 0, 1, 1, 1);
      tick(0, 1, 1, 1, 1);
      repeat (30) tick(0, 0, 1, 1, 1);
      for (int k = 0; k < 3000; k++)
         tick($urandom_range(199) == 0, $urandom_range(3) == 0, $urandom_range(3) != 0,
              $urandom_range(2) != 0, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fft4_seq_ctrl.md
Name: fft4_seq_ctrl

Overview:
Sequencer for the 4-point in-place FFT core. It loads four complex samples into the shared 4-word working buffer and drives the butterfly-input mux select through stage 1 (sel=1) and stage 2 (sel=2). After each stage it writes the butterfly results back in place. It then drains the result in bit-reversed order. It sits between the sample source/sink handshakes and the buffer/mux/butterfly datapath.

Parameters:
BFLY_LAT, 1, butterfly datapath latency in cycles from the sel change to valid results (legal range 1..15).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  begin one transform; sampled only in IDLE
in_valid  input  1  source has a sample on the data bus
in_ready  output  1  controller accepts a sample this cycle
ld_we  output  1  buffer write enable for the input sample
ld_addr  output  2  buffer address for the input sample
sel  output  2  butterfly mux select: 0=idle, 1=stage 1, 2=stage 2
wb_we  output  1  write all four butterfly outputs back to the buffer (in place)
rd_addr  output  2  buffer read address for the output drain
out_valid  output  1  output sample valid
out_ready  input  1  sink accepts the output sample
out_last  output  1  marks the 4th output sample
busy  output  1  transform in progress
done  output  1  one-cycle pulse at transform completion

Behaviour:
- Synchronous active-high reset on clk. rst has priority over all inputs. On reset, state=IDLE and all counters=0. All outputs are 0 during and after reset: in_ready, ld_we, ld_addr, sel, wb_we, rd_addr, out_valid, out_last, busy, done.
- States: IDLE, LOAD, S1_RUN, S1_WB, S2_RUN, S2_WB, DRAIN, DONE.
- IDLE: busy=0. start=1 moves to LOAD next cycle. start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - ld_we = in_valid & in_ready, combinational.
  - ld_addr = load count (0,1,2,3, natural order).
  - The count increments on each handshake. The handshake at count 3 moves to S1_RUN.
  - in_valid low stalls the state indefinitely.
- S1_RUN: sel=1. The wait counter counts BFLY_LAT cycles, then the state moves to S1_WB.
- S1_WB: one cycle. sel=1 and wb_we=1. Next state is S2_RUN.
- S2_RUN / S2_WB: identical to stage 1 with sel=2. S2_WB moves to DRAIN.
- sel=0 in every state other than S1_RUN, S1_WB, S2_RUN and S2_WB. sel never takes the value 3.
- DRAIN:
  - out_valid=1.
  - rd_addr = bitrev(drain count), giving addresses 0,2,1,3.
  - The buffer read is combinational, so data matches rd_addr in the same cycle.
  - The count advances only on out_valid & out_ready. rd_addr is held stable while stalled.
  - out_last=1 while the count is 3.
  - The handshake at count 3 moves to DONE.
- DONE: done=1 for exactly one cycle, busy still 1. Next state is IDLE.
- busy=1 in all states except IDLE. It is registered from state.
- All counters are 2 bits (wait counter 4 bits). They wrap to 0 on state exit and are never read out of range.
- No overlap between transforms: a start held high during DONE has no effect. A start in the following IDLE cycle begins a new transform.
- Minimum transform latency with ideal handshakes: start → 1 cycle (IDLE→LOAD) + 4 load + 2·(BFLY_LAT+1) + 4 drain + 1 DONE. That is 14 cycles at BFLY_LAT=1.
- Reset mid-operation (any state) aborts the transform. The next cycle is IDLE with all outputs 0, and no done pulse is produced.
- in_ready and out_valid never assert in the same cycle. ld_we and wb_we are never asserted together.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release with start=0 for 10 cycles → all outputs stay 0, busy=0.
- Nominal (BFLY_LAT=1, in_valid and out_ready held 1):
  - pulse start → ld_we on 4 consecutive cycles with ld_addr 0,1,2,3.
  - sel=1 for 2 cycles with wb_we on the 2nd; sel=2 for 2 cycles with wb_we on the 2nd.
  - out_valid 4 cycles, rd_addr 0,2,1,3, out_last on the 4th.
  - done one cycle later. Total 14 cycles from start to done.
- Backpressure: drop in_valid for 3 cycles after the 2nd sample and out_ready for 2 cycles at drain count 1 → ld_addr sequence unchanged; rd_addr held at 2 while stalled; no duplicate or skipped handshakes.
- Latency parameter: BFLY_LAT=4 → each sel phase lasts 5 cycles with wb_we only on the last; total latency 20 cycles.
- Abort: assert rst in S2_RUN → next cycle sel=0, busy=0, no done. A new start then completes normally with full 4-sample load.
- Start while busy: pulse start during LOAD and DRAIN → ignored; exactly one done pulse per transform.
